md_unit: RTL and testbench

- Parametrised multiply/divide unit for the EX stage, owning the HI/LO pair.
- Successor to the fixed 32-bit, fixed-latency MD unit; the operand width and the multiply latency are now parameters.
- Division is now a true iterative restoring divider rather than a fixed delay.
- New behaviour: immediate MTHI/MTLO, a cancel input for exception flush, divide-by-zero reporting, and an optional multiply-accumulate mode.

---
 rtl/md_unit.sv | 168 ++++++++++++++++
 tb/tb_md_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit owning HI/LO, iterative restoring divider
// Optional multiply-accumulate opcodes enabled by defining MD_ACCUM_EN.
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] v1,
  input  logic [WIDTH-1:0] v2,
  input  logic [3:0]       opt,
  input  logic             start,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               q_neg;
  logic               r_neg;

  logic               op_mul, op_div, op_mthi, op_mtlo, op_acc;
  logic               is_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     trial;
  logic               ge;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic [2*WIDTH-1:0] mul_res;

`ifdef MD_ACCUM_EN
  logic acc_en;
  logic acc_sub;
`endif

  always_comb begin
    op_mul    = (opt == 4'b0000) || (opt == 4'b0001);
    op_div    = (opt == 4'b0010) || (opt == 4'b0011);
    op_mthi   = (opt == 4'b0100);
    op_mtlo   = (opt == 4'b0101);
`ifdef MD_ACCUM_EN
    op_acc    = (opt[3:2] == 2'b10);
`else
    op_acc    = 1'b0;
`endif
    is_signed = ~opt[0];
    ext_a     = is_signed ? {{WIDTH{v1[WIDTH-1]}}, v1} : {{WIDTH{1'b0}}, v1};
    ext_b     = is_signed ? {{WIDTH{v2[WIDTH-1]}}, v2} : {{WIDTH{1'b0}}, v2};
    // Truncating the 2W x 2W product to 2W bits yields the correct signed or unsigned result.
    product   = ext_a * ext_b;
    abs_a     = (is_signed && v1[WIDTH-1]) ? -v1 : v1;
    abs_b     = (is_signed && v2[WIDTH-1]) ? -v2 : v2;
  end

  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    ge       = (trial >= {1'b0, dvs});
    rem_next = ge ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ge};
  end

  always_comb begin
    mul_res = prod;
`ifdef MD_ACCUM_EN
    if (acc_en)
      mul_res = acc_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MD_ACCUM_EN
      acc_en   <= 1'b0;
      acc_sub  <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (state != IDLE && cancel) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !cancel) begin
              if (op_mthi) begin
                hi <= v1;
              end else if (op_mtlo) begin
                lo <= v1;
              end else if (op_mul || op_acc) begin
                prod  <= product;
                state <= MUL;
                cnt   <= CW'(MUL_LAT - 1);
`ifdef MD_ACCUM_EN
                acc_en  <= op_acc;
                acc_sub <= opt[1];
`endif
              end else if (op_div) begin
                if (v2 == '0) begin
                  div_zero <= 1'b1;
                end else begin
                  rem   <= '0;
                  quo   <= abs_a;
                  dvs   <= abs_b;
                  r_neg <= is_signed && v1[WIDTH-1];
                  q_neg <= is_signed && (v1[WIDTH-1] ^ v2[WIDTH-1]);
                  state <= DIV;
                  cnt   <= CW'(WIDTH);
                end
              end
            end
          end
          MUL: begin
            if (cnt == '0) begin
              {hi, lo} <= mul_res;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DIV: begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1))
              state <= FIX;
          end
          FIX: begin
            hi    <= r_neg ? -rem : rem;
            lo    <= q_neg ? -quo : quo;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed vector bench for md_unit (WIDTH=32, MUL_LAT=5)
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] v1, v2;
  logic [3:0]  opt;
  logic        start, cancel;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk(clk), .reset(reset), .v1(v1), .v2(v2), .opt(opt),
    .start(start), .cancel(cancel), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  opt;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ecyc;
    logic        edz;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    opt = v.opt; v1 = v.v1; v2 = v.v2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.ecyc == 0) begin
      chk({v.name, " busy"}, busy, 0);
      chk({v.name, " done"}, done, 0);
      chk({v.name, " div_zero"}, div_zero, v.edz);
      chk({v.name, " hi"}, hi, v.ehi);
      chk({v.name, " lo"}, lo, v.elo);
      @(negedge clk);
      chk({v.name, " div_zero clear"}, div_zero, 0);
    end else begin
      cyc = 0;
      while (busy && cyc < 200) begin
        cyc++;
        @(negedge clk);
      end
      chk({v.name, " busy cycles"}, cyc, v.ecyc);
      chk({v.name, " done"}, done, 1);
      chk({v.name, " hi"}, hi, v.ehi);
      chk({v.name, " lo"}, lo, v.elo);
      chk({v.name, " div_zero"}, div_zero, 0);
      @(negedge clk);
      chk({v.name, " done pulse"}, done, 0);
    end
  endtask

  initial begin
    vecs[0]  = '{"mthi",        4'h4, 32'h12345678, 32'h0,        32'h12345678, 32'h0,        0,  1'b0};
    vecs[1]  = '{"mtlo",        4'h5, 32'hAB,       32'h0,        32'h12345678, 32'hAB,       0,  1'b0};
    vecs[2]  = '{"mult_neg",    4'h0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5,  1'b0};
    vecs[3]  = '{"multu_max",   4'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1'b0};
    vecs[4]  = '{"multu_carry", 4'h1, 32'h00010000, 32'h00010000, 32'h1,        32'h0,        5,  1'b0};
    vecs[5]  = '{"divu_100_7",  4'h3, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0};
    vecs[6]  = '{"div_m7_2",    4'h2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
    vecs[7]  = '{"div_min_m1",  4'h2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33, 1'b0};
    vecs[8]  = '{"div_7_m2",    4'h2, 32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 33, 1'b0};
    vecs[9]  = '{"divu_max_1",  4'h3, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 33, 1'b0};
    vecs[10] = '{"divu_5_9",    4'h3, 32'd5,        32'd9,        32'd5,        32'h0,        33, 1'b0};
    vecs[11] = '{"mthi_12",     4'h4, 32'h12,       32'h0,        32'h12,       32'h0,        0,  1'b0};
    vecs[12] = '{"div_by_zero", 4'h2, 32'd9,        32'd0,        32'h12,       32'h0,        0,  1'b1};
    vecs[13] = '{"undef_op",    4'h7, 32'd3,        32'd4,        32'h12,       32'h0,        0,  1'b0};
    vecs[14] = '{"div_m100_7",  4'h2, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 33, 1'b0};
    vecs[15] = '{"mult_min",    4'h0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        5,  1'b0};
    vecs[16] = '{"mthi_77",     4'h4, 32'h77,       32'h0,        32'h77,       32'h0,        0,  1'b0};
    vecs[17] = '{"mtlo_ab",     4'h5, 32'hAB,       32'h0,        32'h77,       32'hAB,       0,  1'b0};

    reset = 1'b0; start = 1'b0; cancel = 1'b0; opt = 4'h0; v1 = '0; v2 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset div_zero", div_zero, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Cancel a DIVU on busy cycle 10, with a MULT start attempted on busy cycle 5.
    @(negedge clk);
    opt = 4'h3; v1 = 32'd50; v2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    opt = 4'h0; v1 = 32'd3; v2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy during div", busy, 1);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy", busy, 0);
    chk("cancel done", done, 0);
    chk("cancel hi", hi, 32'h77);
    chk("cancel lo", lo, 32'hAB);
    @(negedge clk);
    chk("ignored mult busy", busy, 0);
    chk("ignored mult done", done, 0);

    // Cancel on the completing edge of a MULT.
    opt = 4'h0; v1 = 32'd3; v2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mult last busy", busy, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel@done busy", busy, 0);
    chk("cancel@done done", done, 0);
    chk("cancel@done hi", hi, 32'h77);
    chk("cancel@done lo", lo, 32'hAB);

    // cancel together with start in IDLE.
    opt = 4'h0; v1 = 32'd2; v2 = 32'd2; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("idle cancel start busy", busy, 0);
    @(negedge clk);
    chk("idle cancel start done", done, 0);

    // Reset in the middle of a division.
    opt = 4'h2; v1 = 32'd40; v2 = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midreset busy", busy, 0);
    chk("midreset hi", hi, 0);
    chk("midreset lo", lo, 0);
    @(negedge clk);
    chk("midreset done", done, 0);

`ifdef MD_ACCUM_EN
    run_vec('{"acc_mthi",  4'h4, 32'h0,        32'h0, 32'h0, 32'h0,        0, 1'b0});
    run_vec('{"acc_mtlo",  4'h5, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1'b0});
    run_vec('{"maddu_1x1", 4'h9, 32'd1,        32'd1, 32'h1, 32'h0,        5, 1'b0});
    run_vec('{"msub_1x2",  4'hA, 32'd1,        32'd2, 32'h0, 32'hFFFFFFFE, 5, 1'b0});
`else
    run_vec('{"acc_mtlo",   4'h5, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1'b0});
    run_vec('{"maddu_off",  4'h9, 32'd1,        32'd1, 32'h0, 32'hFFFFFFFF, 0, 1'b0});
    run_vec('{"msub_off",   4'hA, 32'd1,        32'd2, 32'h0, 32'hFFFFFFFF, 0, 1'b0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
